axis_frame_accumulator: RTL

- AXI4-Stream frame accumulator that sits between the AXI-DMA MM2S and S2MM channels in the PL.
- Sums up to FRAME_LEN unsigned beats per frame and emits one result beat per frame on a master AXIS port.
- Pulses an interrupt to the PS each time a result is accepted downstream.
- Successor to the fixed 8-beat accumulator, adding:
  - parametrised widths and frame length
  - real tready backpressure
  - tlast-driven frame boundaries
  - wrap or saturate overflow modes
  - frame-length error status

---
 rtl/axis_acc_pkg.sv | 14 +
 rtl/axis_frame_accumulator_if.sv | 29 ++
 rtl/acc_add_sat.sv | 19 +
 rtl/axis_frame_accumulator.sv | 114 +++++++++++
 4 files changed

// File: rtl/axis_acc_pkg.sv
// Shared types and constants for the AXIS frame accumulator.
// FSM states and result sideband bit positions.
package axis_acc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  localparam int TUSER_W       = 2;
  localparam int TUSER_OVF     = 0;
  localparam int TUSER_LEN_ERR = 1;

endpackage

// File: rtl/axis_frame_accumulator_if.sv
// AXI4-Stream bundle for the accumulator ports.
// master drives payload, slave drives tready.
interface axis_frame_accumulator_if #(
  parameter int W  = 32,
  parameter int UW = 1
);

  logic [W-1:0]  tdata;
  logic [UW-1:0] tuser;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (
    output tdata,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/acc_add_sat.sv
// Widened adder with wrap/saturate select.
// Carry out of the top bit is the overflow flag.
module acc_add_sat #(
  parameter int W   = 40,
  parameter int SAT = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign ovf = sum[W];
  assign y   = ((SAT != 0) && sum[W]) ? '1 : sum[W-1:0];

endmodule

// File: rtl/axis_frame_accumulator.sv
// Sums beats of a DMA frame and emits one result beat.
// Frame ends on tlast or after FRAME_LEN beats.
module axis_frame_accumulator
  import axis_acc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 8,
  parameter int SATURATE  = 0,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  axis_frame_accumulator_if.slave   s_axis,
  axis_frame_accumulator_if.master  m_axis,
  output logic [CNT_W-1:0]          o_beat_cnt,
  output logic                      o_intr
);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   beat_ext;
  logic [ACC_W-1:0]   add_y;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               ovf_nxt;
  logic               accept;
  logic               first;
  logic               len_hit;
  logic               frame_end;
  logic               len_err_nxt;
  logic               out_hs;
  logic [ACC_W-1:0]   res_data;
  logic [TUSER_W-1:0] res_user;

  assign s_axis.tready = (state == ST_ACCUM) && i_rst;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign beat_ext      = ACC_W'(s_axis.tdata);
  assign first         = (cnt == '0);
  assign len_hit       = (cnt == CNT_W'(FRAME_LEN - 1));
  assign frame_end     = accept && (s_axis.tlast || len_hit);
  assign len_err_nxt   = !(s_axis.tlast && len_hit);
  assign out_hs        = (state == ST_EMIT) && m_axis.tready;

  acc_add_sat #(
    .W   (ACC_W),
    .SAT (SATURATE)
  ) u_add (
    .a   (acc),
    .b   (beat_ext),
    .y   (add_y),
    .ovf (add_ovf)
  );

  // first beat loads directly, later beats accumulate
  always_comb begin
    acc_nxt = add_y;
    ovf_nxt = ovf | add_ovf;
    if (first) begin
      acc_nxt = beat_ext;
      ovf_nxt = 1'b0;
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_ACCUM;
    else        state <= state_nxt;
  end

  // next state: close frame, then wait for downstream
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ACCUM: if (frame_end)     state_nxt = ST_EMIT;
      ST_EMIT:  if (m_axis.tready) state_nxt = ST_ACCUM;
      default:                     state_nxt = ST_ACCUM;
    endcase
  end

  // accumulator, beat counter, result and interrupt
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      res_data <= '0;
      res_user <= '0;
      o_intr   <= 1'b0;
    end else begin
      o_intr <= out_hs;
      if (accept) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
        cnt <= frame_end ? '0 : cnt + CNT_W'(1);
      end
      if (frame_end) begin
        res_data                <= acc_nxt;
        res_user[TUSER_OVF]     <= ovf_nxt;
        res_user[TUSER_LEN_ERR] <= len_err_nxt;
      end
    end
  end

  assign m_axis.tdata  = res_data;
  assign m_axis.tuser  = res_user;
  assign m_axis.tvalid = (state == ST_EMIT);
  assign m_axis.tlast  = 1'b1;
  assign o_beat_cnt    = cnt;

endmodule
